// File: rtl/fakeram_w16_l512_fifo_ctrl.sv
// Stream FIFO controller around the dual-port fakeram_w16_l512 macro.
// rw0 writes, rw1 reads with 1-cycle latency into a 2-entry register output queue.
module fakeram_w16_l512_fifo_ctrl #(
  parameter int BITS       = 16,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  rw0_clk,
  output logic                  rw0_ce_out,
  output logic                  rw0_we_out,
  output logic [ADDR_WIDTH-1:0] rw0_addr_out,
  output logic [BITS-1:0]       rw0_wd_out,
  input  logic [BITS-1:0]       rw0_rd_in,
  output logic                  rw1_clk,
  output logic                  rw1_ce_out,
  output logic                  rw1_we_out,
  output logic [ADDR_WIDTH-1:0] rw1_addr_out,
  output logic [BITS-1:0]       rw1_wd_out,
  input  logic [BITS-1:0]       rw1_rd_in
);
  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_count_q, ram_count_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [1:0]            oq_count_q, oq_count_d;
  logic                  oq_head_q, oq_head_d;
  logic [1:0][BITS-1:0]  oq_data_q, oq_data_d;
  logic                  push, pop, issue;
  logic [2:0]            oq_future;
  logic                  unused_rd0;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_rd0 = ^rw0_rd_in;
  assign rw0_clk    = clk;
  assign rw1_clk    = clk;

  always_comb begin
    in_ready  = rst_n & (ram_count_q != CW'(WORD_DEPTH));
    push      = in_valid & in_ready;
    out_valid = (oq_count_q != 2'd0);
    out_data  = oq_data_q[oq_head_q];
    pop       = out_valid & out_ready;
    // Occupancy the queue will have once the in-flight read lands; a new read
    // may only be launched if that leaves room for it.
    oq_future = {1'b0, oq_count_q} + {2'b0, rd_pending_q} - {2'b0, pop};
    issue     = rst_n & (ram_count_q != '0) & (oq_future <= 3'd1);

    rw0_ce_out   = push;
    rw0_we_out   = push;
    rw0_addr_out = wr_ptr_q;
    rw0_wd_out   = in_data;
    rw1_ce_out   = issue;
    rw1_we_out   = 1'b0;
    rw1_addr_out = rd_ptr_q;
    rw1_wd_out   = '0;

    level = {1'b0, ram_count_q} + (ADDR_WIDTH+2)'(rd_pending_q) + (ADDR_WIDTH+2)'(oq_count_q);
  end

  always_comb begin
    wr_ptr_d     = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ram_count_d  = ram_count_q + CW'(push) - CW'(issue);
    rd_pending_d = issue;
    oq_count_d   = oq_count_q + 2'(rd_pending_q) - 2'(pop);
    oq_head_d    = oq_head_q ^ pop;
    oq_data_d    = oq_data_q;
    // Issue throttling guarantees at most one resident entry at capture time.
    if (rd_pending_q)
      oq_data_d[oq_head_q ^ oq_count_q[0]] = rw1_rd_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      rd_pending_q <= 1'b0;
      oq_count_q   <= '0;
      oq_head_q    <= 1'b0;
      oq_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      rd_pending_q <= rd_pending_d;
      oq_count_q   <= oq_count_d;
      oq_head_q    <= oq_head_d;
      oq_data_q    <= oq_data_d;
    end
  end
endmodule

// File: tb/tb_fakeram_w16_l512_fifo_ctrl.sv
// Bench for fakeram_w16_l512_fifo_ctrl with a behavioural macro model and a
// scoreboard queue filled on accepted pushes and drained by an output monitor.
module tb_fakeram_w16_l512_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [10:0] level;
  logic        rw0_clk, rw0_ce_out, rw0_we_out, rw1_clk, rw1_ce_out, rw1_we_out;
  logic [8:0]  rw0_addr_out, rw1_addr_out;
  logic [15:0] rw0_wd_out, rw1_wd_out;
  logic [15:0] rw0_rd_in, rw1_rd_in;

  logic [15:0] mem [512];
  logic [15:0] exp_q [$];
  int          acc, popn;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  fakeram_w16_l512_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .rw0_clk(rw0_clk), .rw0_ce_out(rw0_ce_out), .rw0_we_out(rw0_we_out),
    .rw0_addr_out(rw0_addr_out), .rw0_wd_out(rw0_wd_out), .rw0_rd_in(rw0_rd_in),
    .rw1_clk(rw1_clk), .rw1_ce_out(rw1_ce_out), .rw1_we_out(rw1_we_out),
    .rw1_addr_out(rw1_addr_out), .rw1_wd_out(rw1_wd_out), .rw1_rd_in(rw1_rd_in)
  );

  // Macro model: synchronous write on rw0, 1-cycle registered read on rw1.
  assign rw0_rd_in = 16'h0;
  always @(posedge rw0_clk) if (rw0_ce_out && rw0_we_out) mem[rw0_addr_out] <= rw0_wd_out;
  always @(posedge rw1_clk) if (rw1_ce_out && !rw1_we_out) rw1_rd_in <= mem[rw1_addr_out];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: level bookkeeping, same-address hazard, push recording, pop checking.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc  = 0;
      popn = 0;
    end else begin
      check("level", 32'(level), 32'(acc - popn));
      if (rw0_ce_out && rw1_ce_out)
        check("same_addr", 32'(rw0_addr_out == rw1_addr_out), 32'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc++;
      end
      if (out_valid && out_ready) begin
        popn++;
        if (exp_q.size() == 0) check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    out_ready = 1'b1;
    sample();
    while (level != 0 && w < 1200) begin step(); sample(); w++; end
    check(nm, 32'(level), 32'd0);
    check({nm, "_sb"}, 32'(exp_q.size()), 32'd0);
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b0;
    repeat (3) begin
      step(); sample();
      check("rst_rw0_ce", 32'(rw0_ce_out), 0);
      check("rst_rw1_ce", 32'(rw1_ce_out), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_level", 32'(level), 0);
    end

    // Single word latency
    step(); rst_n = 1'b1; in_valid = 1'b1; in_data = 16'hA5A5;
    sample();
    check("sw_rw0_ce", 32'(rw0_ce_out), 1);
    check("sw_rw0_we", 32'(rw0_we_out), 1);
    check("sw_rw0_addr", 32'(rw0_addr_out), 0);
    check("sw_rw0_wd", 32'(rw0_wd_out), 32'hA5A5);
    step(); in_valid = 1'b0; sample();
    check("sw_rw1_ce", 32'(rw1_ce_out), 1);
    check("sw_rw1_addr", 32'(rw1_addr_out), 0);
    check("sw_lvl1", 32'(level), 1);
    step(); sample();
    check("sw_valid_c2", 32'(out_valid), 0);
    check("sw_lvl2", 32'(level), 1);
    step(); sample();
    check("sw_valid_c3", 32'(out_valid), 1);
    check("sw_data_c3", 32'(out_data), 32'hA5A5);
    check("sw_lvl3", 32'(level), 1);
    drain("sw_drain");

    // Back-to-back streaming, pointers wrap twice
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 1024; i++) begin
          step(); in_valid = 1'b1; in_data = i[15:0];
          sample(); check("st_in_ready", 32'(in_ready), 1);
        end
        step(); in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        check("st_first", 32'(out_valid), 1);
        for (int k = 1; k < 1024; k++) begin
          @(negedge clk); check("st_gap", 32'(out_valid), 1);
        end
      end
    join
    drain("st_drain");

    // Fill to capacity with the consumer stalled
    begin
      int n;
      n = 0;
      for (int k = 0; k < 600; k++) begin
        step(); in_valid = 1'b1; in_data = 16'h4000 + 16'(n);
        sample();
        if (in_ready) n++; else break;
      end
      check("full_count", 32'(n), 514);
      check("full_level", 32'(level), 514);
    end
    step(); in_valid = 1'b0; out_ready = 1'b1; sample();
    check("full_issue", 32'(rw1_ce_out), 1);
    check("full_ready_same", 32'(in_ready), 0);
    step(); sample();
    check("full_ready_next", 32'(in_ready), 1);
    drain("full_drain");

    // Random valid/ready traffic
    for (int k = 0; k < 10000; k++) begin
      step();
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 3);
    end
    step(); in_valid = 1'b0;
    drain("rnd_drain");

    // Reset with a read in flight
    for (int k = 0; k < 101; k++) begin
      step(); in_valid = 1'b1; in_data = 16'h5000 + k[15:0];
    end
    step(); in_valid = 1'b0;
    repeat (3) step();
    sample(); check("mr_level101", 32'(level), 101);
    step(); out_ready = 1'b1; sample();
    step(); out_ready = 1'b0; sample();
    check("mr_level100", 32'(level), 100);
    check("mr_pending", 32'(dut.rd_pending_q), 1);
    step(); rst_n = 1'b0; sample();
    step(); sample();
    check("mr_level0", 32'(level), 0);
    check("mr_valid0", 32'(out_valid), 0);
    step(); rst_n = 1'b1; in_valid = 1'b1; in_data = 16'h1234; sample();
    check("mr_rw0_addr", 32'(rw0_addr_out), 0);
    check("mr_rw0_ce", 32'(rw0_ce_out), 1);
    step(); in_valid = 1'b0;
    drain("mr_drain");
    check("mr_popn", 32'(popn), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fakeram_w16_l512_fifo_ctrl.md
Name: fakeram_w16_l512_fifo_ctrl

Overview:
- Initiator-side controller for the dual-port fakeram_w16_l512 SRAM macro. It turns the macro into a valid/ready stream FIFO for CNN activation and weight buffering.
- Port rw0 is the write port. Port rw1 is the read port, and its read latency is exactly 1 cycle.
- A 2-entry output queue gives full-throughput streaming even with the RAM's 1-cycle read latency.
- The block sits between a producer stage and the MAC array feeder.

Parameters:
- BITS, 16, data word width; must match the macro.
- WORD_DEPTH, 512, number of RAM words.
- ADDR_WIDTH, 9, RAM address width; equals clog2(WORD_DEPTH).

Ports:
- clk  in  1  single clock; also driven out to both macro clocks.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word.
- in_data  in  BITS  write data.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the word.
- out_data  out  BITS  head word.
- level  out  ADDR_WIDTH+2  total words held.
- rw0_clk  out  1  equals clk.
- rw0_ce_out  out  1  port 0 chip enable.
- rw0_we_out  out  1  port 0 write enable.
- rw0_addr_out  out  ADDR_WIDTH  write address.
- rw0_wd_out  out  BITS  write data.
- rw0_rd_in  in  BITS  unused.
- rw1_clk  out  1  equals clk.
- rw1_ce_out  out  1  port 1 chip enable.
- rw1_we_out  out  1  tied to 0.
- rw1_addr_out  out  ADDR_WIDTH  read address.
- rw1_wd_out  out  BITS  tied to 0.
- rw1_rd_in  in  BITS  read data; valid the cycle after a read is issued.

Behaviour:
- Reset is synchronous and active-low. While rst_n=0 at a clk edge:
  - wr_ptr, rd_ptr and ram_count are set to 0.
  - rd_pending is set to 0, oq_count is set to 0, and the oq data is set to 0.
  - Outputs during and immediately after reset: out_valid=0, out_data=0, level=0.
  - in_ready, rw0_ce_out, rw0_we_out and rw1_ce_out are forced to 0 combinationally while rst_n=0.
  - Reset mid-operation discards every word, including an in-flight read.
- Write side:
  - in_ready = (ram_count != WORD_DEPTH).
  - push = in_valid & in_ready.
  - On push: rw0_ce_out=1, rw0_we_out=1, rw0_addr_out=wr_ptr, rw0_wd_out=in_data.
  - wr_ptr increments and wraps from WORD_DEPTH-1 to 0.
  - Otherwise rw0_ce_out=0 and rw0_we_out=0.
- Output queue:
  - 2-entry FIFO in registers; oq_count is 0..2.
  - out_valid = (oq_count != 0); out_data = oq head.
  - pop = out_valid & out_ready.
- Read issue:
  - issue = (ram_count != 0) & ((oq_count + rd_pending - pop) <= 1).
  - This combinationally depends on out_ready; that path is permitted.
  - On issue: rw1_ce_out=1, rw1_addr_out=rd_ptr. rd_ptr increments and wraps.
  - The RAM slot counts as freed on issue.
  - rd_pending <= issue.
- Capture: when rd_pending=1, rw1_rd_in is written into the oq tail that same cycle.
- Count updates:
  - ram_count <= ram_count + push - issue.
  - oq_count <= oq_count + rd_pending - pop.
- level = ram_count + rd_pending + oq_count. Maximum capacity is WORD_DEPTH+2.
- Latency: for a word pushed in cycle c0 into an empty controller, rw1 is issued in c0+1, captured in c0+2, and out_valid=1 in c0+3.
- Steady state with in_valid=out_ready=1 continuously sustains 1 word per cycle.
- Ordering: strict FIFO; no word is lost or duplicated.
- Same-address hazard: read and write never target the same address in one cycle.
  - issue uses the registered ram_count.
  - When ram_count=WORD_DEPTH, push is blocked.
- Full: in_ready=0 at ram_count=WORD_DEPTH. A pop in that cycle does not raise in_ready in the same cycle; issue frees a slot for the next cycle.
- Empty: out_valid=0. An out_ready with no valid word has no effect.
- Simultaneous push and pop are allowed in every state, including the push into an empty controller.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> rw0_ce_out=0, rw1_ce_out=0, in_ready=0, out_valid=0, level=0.
- Single word: push 0xA5A5 at c0 with out_ready=0 -> rw0_addr_out=0 at c0; rw1_ce_out=1 with rw1_addr_out=0 at c0+1; out_valid=1 with out_data=0xA5A5 at c0+3; level stays 1 from c0+1 onward.
- Streaming: push 0x0000..0x03FF back-to-back with out_ready=1 -> outputs appear in order with no gaps after the first, 1024 words total, and both pointers wrap past 511.
- Full and backpressure: out_ready=0, push until in_ready=0 -> exactly 514 words accepted (level=514, ram_count=512). Then raise out_ready -> all 514 drain in order; in_ready returns to 1 one cycle after the first issue.
- Random valid/ready: 50% in_valid, 30% out_ready for 10k cycles -> scoreboard matches, level equals accepted minus popped, and no rw0/rw1 same-address cycle occurs.
- Reset mid-stream: assert rst_n=0 with level=100 and rd_pending=1 -> next cycle level=0 and out_valid=0. After release, push 0x1234 -> it is output as 0x1234 from address 0.
